timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_pkg.sv | 15 +
 rtl/tick_cnt.sv | 35 +++
 rtl/timer_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer scheduler.
//   DEF_NREQ / DEF_N : default requester count and tick-counter width
//   state_t          : scheduler FSM state encoding
package timer_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_N    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_cnt.sv
// tick_cnt: N-bit tick counter with synchronous clear, count enable and a
// terminal-compare flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : increment by one this cycle
//   term       : terminal value compared against the count
//   count      : current count
//   tc         : count == term
module tick_cnt
  import timer_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] term,
  output logic [N-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + N'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin arbiter sharing one tick counter among NREQ
// timeout requesters. A granted request runs for load+1 ticks and then
// pulses its done bit, unless the grantee cancels first.
//   clk, rst_n : clock, asynchronous active-low reset
//   pwr_off    : synchronous clear of all state, highest priority
//   req        : per-requester timeout request (level)
//   load_val   : per-requester load, slice i = [i*N +: N]
//   cancel     : per-requester abort, honoured only for the grantee in RUN
//   grant      : one-hot, high through the RUN phase of the served requester
//   done       : one-hot, one-cycle pulse on expiry
//   busy       : FSM not in IDLE
//   count      : current tick count
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned N    = DEF_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_off,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] load_val,
  input  logic [NREQ-1:0]   cancel,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [N-1:0]    ld_reg;
  logic [PW-1:0]   pick;
  logic [N-1:0]    pick_ld;
  logic [PW-1:0]   win_next;
  logic            cnt_clr;
  logic            cnt_en;
  logic            cnt_tc;

  // Round-robin selection: first requester at or above ptr, wrapping.
  always_comb begin
    int unsigned idx;
    int unsigned sel;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    sel     = 32'(pick);
    pick_ld = load_val[sel*N +: N];
  end

  always_comb begin
    win_next = PW'((32'(win) + 1) % NREQ);
  end

  // Counter is cleared on every new grant; it stops at ld_reg so a full-range
  // load never wraps.
  assign cnt_clr = pwr_off || ((state == IDLE) && (|req));
  assign cnt_en  = (state == RUN) && !cnt_tc;

  tick_cnt #(.N(N)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (ld_reg),
    .count (count),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      done   <= '0;
      ld_reg <= '0;
      ptr    <= '0;
      win    <= '0;
    end else if (pwr_off) begin
      state  <= IDLE;
      grant  <= '0;
      done   <= '0;
      ld_reg <= '0;
      ptr    <= '0;
      win    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            win    <= pick;
            ld_reg <= pick_ld;
            grant  <= NREQ'(1) << pick;
            state  <= RUN;
          end
        end
        RUN: begin
          // Cancel is checked before expiry so a coincident cancel suppresses done.
          if (cancel[win]) begin
            grant <= '0;
            ptr   <= win_next;
            state <= IDLE;
          end else if (cnt_tc) begin
            grant <= '0;
            done  <= NREQ'(1) << win;
            ptr   <= win_next;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          done  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
